// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared definitions for the fetch front end:
//   - NOP instruction word presented when no real instruction is available
//   - fetch FSM state encoding
//   - 2-bit branch predictor counter encodings and saturating update helper
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   localparam logic [31:0] NOP = 32'h2000_0000;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_MISS_WAIT  = 2'd1,
      ST_MISS_FLUSH = 2'd2,
      ST_FILLED     = 2'd3
   } fetch_state_e;

   localparam logic [1:0] CTR_SNT = 2'b00;
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;
   localparam logic [1:0] CTR_ST  = 2'b11;

   // Saturating move of a 2-bit counter toward the resolved direction.
   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != CTR_ST) res = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) res = ctr - 2'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// -----------------------------------------------------------------------------
// fetch_btb
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational on lk_pc_i; the update port writes on the clock, so
// an update to the entry being looked up becomes visible the following cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset (clears valid bits)
//   lk_pc_i           lookup PC
//   lk_taken_o        valid & tag match & counter predicts taken
//   lk_target_o       predicted target, zero when not predicted taken
//   upd_valid_i       resolved branch update strobe
//   upd_pc_i          PC of the resolved branch
//   upd_taken_i       resolved direction
//   upd_target_i      resolved target
// -----------------------------------------------------------------------------
module fetch_btb
   import fetch_stage_pkg::*;
#(
   parameter int BTB_ENTRIES = 16,
   parameter int VPC_BITS    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [VPC_BITS-1:0] lk_pc_i,
   output logic                lk_taken_o,
   output logic [VPC_BITS-1:0] lk_target_o,
   input  logic                upd_valid_i,
   input  logic [VPC_BITS-1:0] upd_pc_i,
   input  logic                upd_taken_i,
   input  logic [VPC_BITS-1:0] upd_target_i
);

   localparam int IDX   = $clog2(BTB_ENTRIES);
   localparam int TAG_W = VPC_BITS - IDX - 2;

   logic                valid_vec  [BTB_ENTRIES];
   logic [TAG_W-1:0]    tag_vec    [BTB_ENTRIES];
   logic [1:0]          ctr_vec    [BTB_ENTRIES];
   logic [VPC_BITS-1:0] target_vec [BTB_ENTRIES];

   logic [IDX-1:0]   lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX-1:0]   upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic [1:0]       upd_ctr_next;
   logic             unused_pc_bits;

   // Instruction alignment bits never participate in indexing or tagging.
   assign unused_pc_bits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

   assign lk_idx  = lk_pc_i[IDX+1:2];
   assign lk_tag  = lk_pc_i[VPC_BITS-1:IDX+2];
   assign lk_hit  = valid_vec[lk_idx] && (tag_vec[lk_idx] == lk_tag);

   assign lk_taken_o  = lk_hit && ctr_vec[lk_idx][1];
   assign lk_target_o = lk_taken_o ? target_vec[lk_idx] : '0;

   assign upd_idx      = upd_pc_i[IDX+1:2];
   assign upd_tag      = upd_pc_i[VPC_BITS-1:IDX+2];
   assign upd_hit      = valid_vec[upd_idx] && (tag_vec[upd_idx] == upd_tag);
   // A taken branch that misses allocates weakly-taken; otherwise the counter
   // saturates toward the resolved direction.
   assign upd_ctr_next = (upd_taken_i && !upd_hit) ? CTR_WT
                                                   : ctr_step(ctr_vec[upd_idx], upd_taken_i);

   genvar gi;
   generate
      for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_entry
         logic                valid_q;
         logic [TAG_W-1:0]    tag_q;
         logic [1:0]          ctr_q;
         logic [VPC_BITS-1:0] target_q;
         logic                wr_sel;

         assign wr_sel = upd_valid_i && (upd_idx == IDX'(gi));

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
            end else if (wr_sel && upd_taken_i) begin
               valid_q <= 1'b1;
            end
         end

         // Not-taken misses leave the entry untouched.
         always_ff @(posedge clk) begin
            if (wr_sel) begin
               if (upd_taken_i) begin
                  tag_q    <= upd_tag;
                  target_q <= upd_target_i;
                  ctr_q    <= upd_ctr_next;
               end else if (upd_hit) begin
                  ctr_q    <= upd_ctr_next;
               end
            end
         end

         assign valid_vec[gi]  = valid_q;
         assign tag_vec[gi]    = tag_q;
         assign ctr_vec[gi]    = ctr_q;
         assign target_vec[gi] = target_q;
      end
   endgenerate

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Pipeline front end: owns the fetch PC, looks up the instruction cache,
// tracks a single outstanding miss, predicts the next PC through the BTB and
// applies EX-stage redirects.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   stall_D, MEM_stall, Itlb_stall hold sources (MEM_stall also blocks redirects)
//   EX_taken, EX_target_pc         redirect request and target
//   bp_upd_*                       resolved-branch BTB update
//   ic_req, ic_addr                cache lookup strobe and address
//   ic_hit, ic_data                same-cycle hit and data
//   ic_resp_valid, ic_resp_data    miss fill pulse and data
//   F_pc, F_inst, F_valid          presented instruction bundle
//   F_BP_taken, F_BP_target_pc     prediction for F_pc (zero when !F_valid)
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int                    XLEN        = 32,
   parameter int                    VPC_BITS    = 32,
   parameter int                    BTB_ENTRIES = 16,
   parameter logic [VPC_BITS-1:0]   RESET_PC    = 32'h0000_1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_D,
   input  logic                MEM_stall,
   input  logic                Itlb_stall,
   input  logic                EX_taken,
   input  logic [VPC_BITS-1:0] EX_target_pc,
   input  logic                bp_upd_valid,
   input  logic [VPC_BITS-1:0] bp_upd_pc,
   input  logic                bp_upd_taken,
   input  logic [VPC_BITS-1:0] bp_upd_target,
   output logic                ic_req,
   output logic [VPC_BITS-1:0] ic_addr,
   input  logic                ic_hit,
   input  logic [XLEN-1:0]     ic_data,
   input  logic                ic_resp_valid,
   input  logic [XLEN-1:0]     ic_resp_data,
   output logic [VPC_BITS-1:0] F_pc,
   output logic [XLEN-1:0]     F_inst,
   output logic                F_valid,
   output logic                F_BP_taken,
   output logic [VPC_BITS-1:0] F_BP_target_pc
);

   fetch_state_e        state_q, state_d;
   logic [VPC_BITS-1:0] pc_q, pc_d;
   logic [XLEN-1:0]     inst_buf_q, inst_buf_d;

   logic                hold;
   logic                redirect;
   logic                advance;
   logic                pred_taken;
   logic [VPC_BITS-1:0] pred_target;

   assign hold     = stall_D | MEM_stall | Itlb_stall;
   assign redirect = EX_taken & ~MEM_stall;
   assign advance  = F_valid & ~hold & ~redirect;

   fetch_btb #(
      .BTB_ENTRIES (BTB_ENTRIES),
      .VPC_BITS    (VPC_BITS)
   ) u_btb (
      .clk          (clk),
      .rst          (rst),
      .lk_pc_i      (pc_q),
      .lk_taken_o   (pred_taken),
      .lk_target_o  (pred_target),
      .upd_valid_i  (bp_upd_valid),
      .upd_pc_i     (bp_upd_pc),
      .upd_taken_i  (bp_upd_taken),
      .upd_target_i (bp_upd_target)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         pc_q       <= RESET_PC;
         inst_buf_q <= XLEN'(NOP);
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inst_buf_q <= inst_buf_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      inst_buf_d = inst_buf_q;
      unique case (state_q)
         ST_RUN: begin
            if (ic_req && !ic_hit && !redirect) state_d = ST_MISS_WAIT;
         end
         ST_MISS_WAIT: begin
            // A redirect that coincides with the fill drops the fill and
            // restarts immediately; otherwise the late fill must be flushed.
            if (redirect) begin
               state_d = ic_resp_valid ? ST_RUN : ST_MISS_FLUSH;
            end else if (ic_resp_valid) begin
               state_d    = ST_FILLED;
               inst_buf_d = ic_resp_data;
            end
         end
         ST_MISS_FLUSH: begin
            if (ic_resp_valid) state_d = ST_RUN;
         end
         ST_FILLED: begin
            if (advance || redirect) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      if (redirect)                    pc_d = EX_target_pc;
      else if (advance && pred_taken)  pc_d = pred_target;
      else if (advance)                pc_d = pc_q + VPC_BITS'(4);
      else                             pc_d = pc_q;
   end

   // Output logic; reset forces the bundle to its reset-state values.
   always_comb begin
      ic_req  = 1'b0;
      F_valid = 1'b0;
      F_inst  = XLEN'(NOP);
      unique case (state_q)
         ST_RUN: begin
            ic_req = ~Itlb_stall;
            if (ic_req && ic_hit) begin
               F_valid = 1'b1;
               F_inst  = ic_data;
            end
         end
         ST_FILLED: begin
            F_valid = 1'b1;
            F_inst  = inst_buf_q;
         end
         default: ;
      endcase
      if (rst) begin
         ic_req  = 1'b0;
         F_valid = 1'b0;
         F_inst  = XLEN'(NOP);
      end
   end

   assign F_pc           = rst ? RESET_PC : pc_q;
   assign ic_addr        = F_pc;
   assign F_BP_taken     = F_valid & pred_taken;
   assign F_BP_target_pc = F_valid ? pred_target : '0;

endmodule
